reg_file_cmd_ctrl: RTL and testbench



---
 rtl/reg_file_cmd_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_reg_file_cmd_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_cmd_ctrl
// Brief    : Byte-stream command parser driving an 8x16 register file, with
//            two-byte read-data return on a valid/ready transmit interface.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_cmd_ctrl #(
    parameter logic [7:0]  WR_CMD      = 8'hAA,
    parameter logic [7:0]  RD_CMD      = 8'hBB,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic [7:0]        TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    output logic              RF_WrEn,
    output logic              RF_RdEn,
    output logic [ADDR_W-1:0] RF_Address,
    output logic [15:0]       RF_WrData,
    input  logic [15:0]       RF_RdData,
    output logic              BUSY,
    output logic              FRAME_ERR
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_GET_ADDR  = 4'd1,
        S_GET_DLO   = 4'd2,
        S_GET_DHI   = 4'd3,
        S_WRITE     = 4'd4,
        S_READ      = 4'd5,
        S_READ_WAIT = 4'd6,
        S_TX_LO     = 4'd7,
        S_TX_HI     = 4'd8
    } state_t;

    state_t             state_q, state_d;
    logic               is_rd_q, is_rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         cap_hi_q, cap_hi_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               wren_q, wren_d;
    logic               rden_q, rden_d;
    logic [7:0]         txd_q, txd_d;
    logic               txv_q, txv_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               in_frame;

    assign in_frame = (state_q == S_GET_ADDR) || (state_q == S_GET_DLO) ||
                      (state_q == S_GET_DHI);

    always_comb begin
        state_d  = state_q;
        is_rd_d  = is_rd_q;
        cnt_d    = '0;
        cap_hi_d = cap_hi_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        txd_d    = txd_q;
        txv_d    = txv_q;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (RX_VALID) begin
                    if (RX_DATA == WR_CMD || RX_DATA == RD_CMD) begin
                        is_rd_d = (RX_DATA == RD_CMD);
                        state_d = S_GET_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_GET_ADDR: begin
                if (RX_VALID) begin
                    if ((RX_DATA >> ADDR_W) != 8'd0) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        addr_d = RX_DATA[ADDR_W-1:0];
                        if (is_rd_q) begin
                            rden_d  = 1'b1;
                            state_d = S_READ;
                        end else begin
                            state_d = S_GET_DLO;
                        end
                    end
                end
            end
            S_GET_DLO: begin
                if (RX_VALID) begin
                    wdata_d[7:0] = RX_DATA;
                    state_d      = S_GET_DHI;
                end
            end
            S_GET_DHI: begin
                if (RX_VALID) begin
                    wdata_d[15:8] = RX_DATA;
                    wren_d        = 1'b1;
                    state_d       = S_WRITE;
                end
            end
            S_WRITE: begin
                err_d   = RX_VALID;
                state_d = S_IDLE;
            end
            S_READ: begin
                err_d   = RX_VALID;
                state_d = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                // Read data is registered inside the register file, so it is
                // only valid one cycle after the read strobe.
                err_d    = RX_VALID;
                cap_hi_d = RF_RdData[15:8];
                txd_d    = RF_RdData[7:0];
                txv_d    = 1'b1;
                state_d  = S_TX_LO;
            end
            S_TX_LO: begin
                err_d = RX_VALID;
                if (TX_READY) begin
                    txd_d   = cap_hi_q;
                    state_d = S_TX_HI;
                end
            end
            S_TX_HI: begin
                err_d = RX_VALID;
                if (TX_READY) begin
                    txv_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A byte arriving in the same cycle as expiry takes precedence.
        if (in_frame && !RX_VALID) begin
            if (cnt_q == CNT_LAST) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            is_rd_q  <= 1'b0;
            cnt_q    <= '0;
            cap_hi_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            txd_q    <= '0;
            txv_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_rd_q  <= is_rd_d;
            cnt_q    <= cnt_d;
            cap_hi_q <= cap_hi_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            txd_q    <= txd_d;
            txv_q    <= txv_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign TX_DATA    = txd_q;
    assign TX_VALID   = txv_q;
    assign RF_WrEn    = wren_q;
    assign RF_RdEn    = rden_q;
    assign RF_Address = addr_q;
    assign RF_WrData  = wdata_q;
    assign BUSY       = busy_q;
    assign FRAME_ERR  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_cmd_ctrl
// Brief    : Directed plus randomized bench for reg_file_cmd_ctrl against a
//            frame-level reference model and a behavioural register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_cmd_ctrl;

    localparam int T = 20;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_VALID = 1'b0;
    logic        TX_READY = 1'b0;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        RF_WrEn;
    logic        RF_RdEn;
    logic [2:0]  RF_Address;
    logic [15:0] RF_WrData;
    logic [15:0] RF_RdData;
    logic        BUSY;
    logic        FRAME_ERR;

    int n_total = 0;
    int n_pass  = 0;

    always #5 CLK = ~CLK;

    reg_file_cmd_ctrl #(
        .WR_CMD(8'hAA), .RD_CMD(8'hBB), .ADDR_W(3), .TIMEOUT_CYC(T)
    ) dut (
        .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
        .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .BUSY(BUSY),
        .FRAME_ERR(FRAME_ERR)
    );

    // Behavioural register file with registered read data.
    logic [15:0] rf_mem [8] = '{default: 16'h0000};
    logic [15:0] rf_rd = 16'h0000;
    always @(posedge CLK) begin
        if (RF_WrEn) rf_mem[RF_Address] <= RF_WrData;
        if (RF_RdEn) rf_rd <= rf_mem[RF_Address];
    end
    assign RF_RdData = rf_rd;

    // Observation of accepted TX bytes and strobe counts.
    logic [7:0] tx_log[$];
    int wr_cnt = 0;
    int rd_cnt = 0;
    always @(posedge CLK) begin
        if (RST) begin
            if (TX_VALID && TX_READY) tx_log.push_back(TX_DATA);
            if (RF_WrEn) wr_cnt++;
            if (RF_RdEn) rd_cnt++;
        end
    end

    // Frame-level reference model: bytes of the frame being collected,
    // a queue of pending strobe cycles {wren,rden}, and pending TX bytes.
    logic [7:0]  m_frame[$];
    logic [1:0]  m_sched[$];
    logic [7:0]  m_txq[$];
    int          m_silent;
    logic [2:0]  m_addr;
    logic [15:0] m_wdata;
    logic        m_err;
    logic [15:0] m_mem [8] = '{default: 16'h0000};

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_frame.delete(); m_sched.delete(); m_txq.delete();
            m_silent = 0; m_addr = 3'd0; m_wdata = 16'h0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_sched.size() > 0) begin
                void'(m_sched.pop_front());
                if (RX_VALID) m_err = 1'b1;
            end else if (m_txq.size() > 0) begin
                if (TX_READY) void'(m_txq.pop_front());
                if (RX_VALID) m_err = 1'b1;
            end else if (RX_VALID) begin
                m_silent = 0;
                case (m_frame.size())
                    0: begin
                        if (RX_DATA == 8'hAA || RX_DATA == 8'hBB) m_frame.push_back(RX_DATA);
                        else m_err = 1'b1;
                    end
                    1: begin
                        if (RX_DATA > 8'd7) begin
                            m_err = 1'b1;
                            m_frame.delete();
                        end else begin
                            m_addr = RX_DATA[2:0];
                            if (m_frame[0] == 8'hBB) begin
                                m_sched.push_back(2'b01);
                                m_sched.push_back(2'b00);
                                m_txq.push_back(m_mem[m_addr][7:0]);
                                m_txq.push_back(m_mem[m_addr][15:8]);
                                m_frame.delete();
                            end else begin
                                m_frame.push_back(RX_DATA);
                            end
                        end
                    end
                    2: begin
                        m_wdata[7:0] = RX_DATA;
                        m_frame.push_back(RX_DATA);
                    end
                    default: begin
                        m_wdata[15:8] = RX_DATA;
                        m_mem[m_addr] = m_wdata;
                        m_sched.push_back(2'b10);
                        m_frame.delete();
                    end
                endcase
            end else if (m_frame.size() > 0) begin
                m_silent++;
                if (m_silent == T) begin
                    m_err = 1'b1;
                    m_frame.delete();
                    m_silent = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] b);
        RX_VALID = 1'b1;
        RX_DATA  = b;
        tick();
        RX_VALID = 1'b0;
        RX_DATA  = 8'($urandom);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        chk("rst_tx_data", TX_DATA, 0);
        chk("rst_tx_valid", TX_VALID, 0);
        chk("rst_wren", RF_WrEn, 0);
        chk("rst_rden", RF_RdEn, 0);
        chk("rst_addr", RF_Address, 0);
        chk("rst_wdata", RF_WrData, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_err", FRAME_ERR, 0);
        tick(2);
        RST = 1'b1;
    endtask

    function automatic logic [7:0] pick();
        int r = $urandom_range(0, 99);
        if (r < 25) return 8'hAA;
        if (r < 45) return 8'hBB;
        if (r < 80) return 8'($urandom_range(0, 7));
        return 8'($urandom);
    endfunction

    initial begin
        int base;
        int snap;
        fork
            forever begin
                @(negedge CLK);
                if (RST) begin
                    chk("busy", BUSY, (m_frame.size() > 0 || m_sched.size() > 0 || m_txq.size() > 0));
                    chk("wren", RF_WrEn, (m_sched.size() > 0) ? m_sched[0][1] : 1'b0);
                    chk("rden", RF_RdEn, (m_sched.size() > 0) ? m_sched[0][0] : 1'b0);
                    chk("frame_err", FRAME_ERR, m_err);
                    chk("addr", RF_Address, m_addr);
                    chk("wdata", RF_WrData, m_wdata);
                    chk("tx_valid", TX_VALID, (m_sched.size() == 0 && m_txq.size() > 0));
                    if (m_sched.size() == 0 && m_txq.size() > 0) chk("tx_data", TX_DATA, m_txq[0]);
                end
            end
        join_none

        #3;
        do_reset();

        // Write 0x1234 to address 5.
        snap = wr_cnt;
        send(8'hAA); send(8'h05); send(8'h34); send(8'h12);
        chk("d_wr_en", RF_WrEn, 1);
        chk("d_wr_addr", RF_Address, 5);
        chk("d_wr_data", RF_WrData, 16'h1234);
        chk("d_model_mem", m_mem[5], 16'h1234);
        tick();
        chk("d_wr_end", RF_WrEn, 0);
        chk("d_wr_busy", BUSY, 0);
        chk("d_wr_count", wr_cnt - snap, 1);

        // Read back with TX always ready.
        TX_READY = 1'b1;
        base = tx_log.size();
        snap = rd_cnt;
        send(8'hBB); send(8'h05);
        tick(6);
        chk("d_rd_count", rd_cnt - snap, 1);
        chk("d_rd_nbytes", tx_log.size() - base, 2);
        if (tx_log.size() - base == 2) begin
            chk("d_rd_lo", tx_log[base], 8'h34);
            chk("d_rd_hi", tx_log[base + 1], 8'h12);
        end

        // Read with TX stalled; stray byte meanwhile.
        TX_READY = 1'b0;
        base = tx_log.size();
        send(8'hBB); send(8'h05);
        tick(2);
        for (int i = 0; i < 10; i++) begin
            chk("d_stall_valid", TX_VALID, 1);
            chk("d_stall_data", TX_DATA, 8'h34);
            if (i == 4) begin
                send(8'h77);
                chk("d_stall_err", FRAME_ERR, 1);
            end else begin
                tick();
            end
        end
        TX_READY = 1'b1;
        tick(3);
        chk("d_stall_nbytes", tx_log.size() - base, 2);
        if (tx_log.size() - base == 2) begin
            chk("d_stall_lo", tx_log[base], 8'h34);
            chk("d_stall_hi", tx_log[base + 1], 8'h12);
        end
        TX_READY = 1'b0;

        // Bad command byte and bad address.
        snap = wr_cnt;
        send(8'h55);
        chk("d_badcmd_err", FRAME_ERR, 1);
        chk("d_badcmd_busy", BUSY, 0);
        send(8'hAA); send(8'h09);
        chk("d_badaddr_err", FRAME_ERR, 1);
        chk("d_badaddr_busy", BUSY, 0);
        tick(2);
        chk("d_badaddr_nowr", wr_cnt - snap, 0);

        // Inter-byte timeout, then a normal write.
        send(8'hAA); send(8'h02);
        tick(T - 1);
        chk("d_to_early_err", FRAME_ERR, 0);
        chk("d_to_early_busy", BUSY, 1);
        tick();
        chk("d_to_err", FRAME_ERR, 1);
        chk("d_to_busy", BUSY, 0);
        send(8'hAA); send(8'h02); send(8'hFF); send(8'h00);
        chk("d_to_wr_en", RF_WrEn, 1);
        chk("d_to_wr_addr", RF_Address, 2);
        chk("d_to_wr_data", RF_WrData, 16'h00FF);
        tick();

        // Reset while the high byte is pending, then mid write frame.
        send(8'hBB); send(8'h02);
        tick(2);
        TX_READY = 1'b1;
        tick();
        TX_READY = 1'b0;
        tick(2);
        chk("d_txhi_valid", TX_VALID, 1);
        chk("d_txhi_data", TX_DATA, 8'h00);
        do_reset();
        send(8'hAA); send(8'h03);
        do_reset();
        send(8'hAA); send(8'h06); send(8'hCD); send(8'hAB);
        chk("d_post_wr_en", RF_WrEn, 1);
        chk("d_post_wr_data", RF_WrData, 16'hABCD);
        TX_READY = 1'b1;
        base = tx_log.size();
        tick();
        send(8'hBB); send(8'h06);
        tick(6);
        chk("d_post_nbytes", tx_log.size() - base, 2);
        if (tx_log.size() - base == 2) begin
            chk("d_post_lo", tx_log[base], 8'hCD);
            chk("d_post_hi", tx_log[base + 1], 8'hAB);
        end

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            TX_READY = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 3) tick($urandom_range(15, 25));
            else if ($urandom_range(0, 99) < 35) send(pick());
            else tick();
            if ($urandom_range(0, 999) == 0) do_reset();
        end
        TX_READY = 1'b1;
        tick(T + 10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
